// File: rtl/alu_wb_buffer_if.sv
// Handshake bundle between the ALU, the writeback buffer and the register file.
// The slave modport is the buffer's view; the master modport is its surroundings.
interface alu_wb_buffer_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_n;
  logic              in_z;
  logic              in_c;
  logic              in_v;
  logic [RD_W-1:0]   in_rd;
  logic              in_wen;
  logic              in_set_flags;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_wen;

  modport slave (
    input  in_valid, in_result, in_n, in_z, in_c, in_v, in_rd, in_wen, in_set_flags,
    output in_ready,
    output out_valid, out_result, out_rd, out_wen,
    input  out_ready
  );

  modport master (
    output in_valid, in_result, in_n, in_z, in_c, in_v, in_rd, in_wen, in_set_flags,
    input  in_ready,
    input  out_valid, out_result, out_rd, out_wen,
    output out_ready
  );
endinterface

// File: rtl/alu_wb_buffer.sv
// ALU writeback FIFO plus architectural NZCV register; entries appear one cycle after push.
// in_ready/out_valid depend only on registered count, so no ready/valid combinational paths.
module alu_wb_buffer #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  alu_wb_buffer_if.slave         bus,
  output logic [3:0]             nzcv,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] res_q [DEPTH];
  logic [RD_W-1:0]   rd_q  [DEPTH];
  logic [DEPTH-1:0]  wen_q;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        nzcv_q, nzcv_d;
  logic              push, pop;

  assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  assign bus.out_result = res_q[rd_ptr_q];
  assign bus.out_rd     = rd_q[rd_ptr_q];
  assign bus.out_wen    = wen_q[rd_ptr_q];
  assign nzcv           = nzcv_q;
  assign count          = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    nzcv_d   = nzcv_q;
    if (flush) begin
      // Flush drops the whole queue but leaves the architectural flags alone.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push && bus.in_set_flags) begin
        nzcv_d = {bus.in_n, bus.in_z, bus.in_c, bus.in_v};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      nzcv_q   <= '0;
      wen_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i] <= '0;
        rd_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      nzcv_q   <= nzcv_d;
      if (push && !flush) begin
        res_q[wr_ptr_q] <= bus.in_result;
        rd_q[wr_ptr_q]  <= bus.in_rd;
        wen_q[wr_ptr_q] <= bus.in_wen;
      end
    end
  end
endmodule

// File: tb/tb_alu_wb_buffer.sv
// Randomized and directed bench for alu_wb_buffer against a queue-based reference model.
module tb_alu_wb_buffer;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int DEPTH  = 2;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [RD_W-1:0]   rd;
    logic              wen;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [3:0] nzcv;
  logic [$clog2(DEPTH):0] count;

  alu_wb_buffer_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  alu_wb_buffer #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .nzcv  (nzcv),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t              mq[$];
  logic [3:0]        m_nzcv;
  logic [DATA_W-1:0] dut_pops[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic put(input logic v, input logic [DATA_W-1:0] r, input logic [RD_W-1:0] rd,
                     input logic [3:0] f, input logic sf, input logic ordy);
    bus.in_valid     = v;
    bus.in_result    = r;
    bus.in_rd        = rd;
    bus.in_wen       = 1'b1;
    {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = f;
    bus.in_set_flags = sf;
    bus.out_ready    = ordy;
  endtask

  // Compare outputs with the model, advance the model by one clock, then step the clock.
  task automatic cycle();
    ent_t e;
    bit   m_push, m_pop;
    chk("count", 64'(count), 64'(mq.size()));
    chk("out_valid", bus.out_valid, mq.size() != 0);
    chk("in_ready", bus.in_ready, mq.size() != DEPTH);
    chk("nzcv", nzcv, m_nzcv);
    if (mq.size() != 0) begin
      chk("out_result", bus.out_result, mq[0].res);
      chk("out_rd", bus.out_rd, mq[0].rd);
      chk("out_wen", bus.out_wen, mq[0].wen);
    end
    if (rst_n && !flush && bus.out_valid && bus.out_ready) dut_pops.push_back(bus.out_result);
    if (!rst_n) begin
      mq.delete();
      m_nzcv = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      m_push = bus.in_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() != 0) && bus.out_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        e.res = bus.in_result;
        e.rd  = bus.in_rd;
        e.wen = bus.in_wen;
        mq.push_back(e);
        if (bus.in_set_flags) m_nzcv = {bus.in_n, bus.in_z, bus.in_c, bus.in_v};
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    flush = 1'b0;
    rst_n = 1'b0;
    put(1'b1, 32'hFFFF_FFFF, 5'd31, 4'b1111, 1'b1, 1'b1);
    m_nzcv = '0;

    // Reset held two cycles with traffic present.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 64'(count), 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_nzcv", nzcv, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_rd", bus.out_rd, 0);
    chk("rst_out_wen", bus.out_wen, 0);
    rst_n = 1'b1;

    // Single pass.
    put(1'b1, 32'hDEAD_BEEF, 5'd3, 4'b1000, 1'b1, 1'b0);
    cycle();
    put(1'b0, '0, '0, 4'b0000, 1'b0, 1'b1);
    chk("single_out_valid", bus.out_valid, 1);
    chk("single_out_result", bus.out_result, 32'hDEAD_BEEF);
    chk("single_out_rd", bus.out_rd, 3);
    chk("single_nzcv", nzcv, 4'b1000);
    cycle();
    chk("single_drained", 64'(count), 0);

    // Fill to full; the third push must be refused.
    dut_pops.delete();
    put(1'b1, 32'h11, 5'd1, 4'b0000, 1'b0, 1'b0);
    cycle();
    put(1'b1, 32'h22, 5'd2, 4'b0000, 1'b0, 1'b0);
    cycle();
    put(1'b1, 32'h33, 5'd3, 4'b0000, 1'b0, 1'b1);
    chk("fill_in_ready_full", bus.in_ready, 0);
    cycle();
    put(1'b0, '0, '0, 4'b0000, 1'b0, 1'b1);
    cycle();
    chk("fill_in_ready_back", bus.in_ready, 1);
    cycle();
    chk("fill_pop_count", 64'(dut_pops.size()), 2);
    if (dut_pops.size() == 2) begin
      chk("fill_pop0", dut_pops[0], 32'h11);
      chk("fill_pop1", dut_pops[1], 32'h22);
    end

    // Streaming through the wrap point.
    dut_pops.delete();
    for (int i = 0; i < 20; i++) begin
      put(1'b1, DATA_W'(i + 1), RD_W'(i), 4'b0000, 1'b0, 1'b1);
      if (i > 0) chk("stream_count", 64'(count), 1);
      cycle();
    end
    put(1'b0, '0, '0, 4'b0000, 1'b0, 1'b1);
    cycle();
    chk("stream_pop_count", 64'(dut_pops.size()), 20);
    for (int i = 0; i < 20 && i < dut_pops.size(); i++) chk("stream_order", dut_pops[i], 64'(i + 1));

    // Flags follow issue order, not drain order; a refused push changes nothing.
    put(1'b1, 32'hA, 5'd10, 4'b0100, 1'b1, 1'b0);
    cycle();
    chk("flag_after_A", nzcv, 4'b0100);
    put(1'b1, 32'hB, 5'd11, 4'b0010, 1'b0, 1'b0);
    cycle();
    chk("flag_after_B", nzcv, 4'b0100);
    put(1'b1, 32'hC, 5'd12, 4'b0001, 1'b1, 1'b0);
    cycle();
    chk("flag_C_refused", nzcv, 4'b0100);
    put(1'b0, '0, '0, 4'b0000, 1'b0, 1'b1);
    cycle();
    put(1'b1, 32'hC, 5'd12, 4'b0001, 1'b1, 1'b0);
    cycle();
    chk("flag_after_C", nzcv, 4'b0001);
    chk("flag_count_full", 64'(count), 2);

    // Flush at full with a flag-setting push present.
    put(1'b1, 32'hF0, 5'd7, 4'b1000, 1'b1, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_count", 64'(count), 0);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_nzcv", nzcv, 4'b0001);
    put(1'b1, 32'h55, 5'd5, 4'b0000, 1'b0, 1'b0);
    cycle();
    // Flush with one entry held, so the push would otherwise be accepted.
    put(1'b1, 32'h66, 5'd6, 4'b1010, 1'b1, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush1_count", 64'(count), 0);
    chk("flush1_nzcv", nzcv, 4'b0001);
    put(1'b1, 32'h77, 5'd7, 4'b0110, 1'b1, 1'b0);
    cycle();
    chk("after_flush_push", bus.out_result, 32'h77);
    chk("after_flush_nzcv", nzcv, 4'b0110);

    // Randomized traffic, flushes and resets.
    for (int i = 0; i < 600; i++) begin
      put(1'b0, '0, '0, 4'b0000, 1'b0, 1'b0);
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.in_result    = $urandom;
      bus.in_rd        = RD_W'($urandom);
      bus.in_wen       = $urandom_range(0, 1) == 1;
      {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = 4'($urandom);
      bus.in_set_flags = $urandom_range(0, 1) == 1;
      bus.out_ready    = ($urandom_range(0, 2) != 0);
      flush            = ($urandom_range(0, 15) == 0);
      rst_n            = ($urandom_range(0, 63) != 0);
      cycle();
    end
    rst_n = 1'b1;
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
